// File: rtl/lvda_int_countdn_ctrl.sv
// -----------------------------------------------------------------------------
// lvda_int_countdn_ctrl
//
// Interrupt collection and countdown timer for the LVDA.
//   - Rising edges on INTR (examined only in SAMP cycles) latch pending bits.
//   - A loadable countdown timer raises pending bit NUM_INTR on expiry.
//   - Pending sources, qualified by MASK, drive a single request SINT with
//     the ID of the lowest-index unmasked pending source on INT_ID.
//   - ACK clears the pending bit currently named by INT_ID.
//
// Ports:
//   SIM_CLK   in   1           system clock, rising edge
//   SIM_RST   in   1           asynchronous active-high reset
//   SAMP      in   1           sampling strobe for INTR
//   INTR      in   NUM_INTR    external interrupt lines (levels)
//   MASK      in   NUM_INTR+1  per-source mask, 1 = blocked from SINT
//   ACK       in   1           clear pending bit INT_ID (when SINT=1)
//   CNT_LOAD  in   1           load CNT_VAL into the counter
//   CNT_VAL   in   CNT_W       counter load value
//   CNT_STEP  in   1           countdown tick
//   SINT      out  1           interrupt request
//   INT_ID    out  ID_W        highest-priority unmasked pending source
//   INT_PEND  out  NUM_INTR+1  raw pending register
//   CNT       out  CNT_W       current counter value
//   TC_DONE   out  1           one-cycle pulse on timer expiry
// -----------------------------------------------------------------------------
module lvda_int_countdn_ctrl #(
  parameter int NUM_INTR = 7,
  parameter int CNT_W    = 8,
  parameter int ID_W     = 3
) (
  input  logic                SIM_CLK,
  input  logic                SIM_RST,
  input  logic                SAMP,
  input  logic [NUM_INTR-1:0] INTR,
  input  logic [NUM_INTR:0]   MASK,
  input  logic                ACK,
  input  logic                CNT_LOAD,
  input  logic [CNT_W-1:0]    CNT_VAL,
  input  logic                CNT_STEP,
  output logic                SINT,
  output logic [ID_W-1:0]     INT_ID,
  output logic [NUM_INTR:0]   INT_PEND,
  output logic [CNT_W-1:0]    CNT,
  output logic                TC_DONE
);

  localparam int NUM_SRC = NUM_INTR + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tmr_state_t;

  tmr_state_t          state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic                expire;
  logic                tc_done;

  logic [NUM_INTR-1:0] prev;
  logic [NUM_SRC-1:0]  pend;
  logic [NUM_SRC-1:0]  active;
  logic [NUM_SRC-1:0]  set_vec;
  logic [NUM_SRC-1:0]  clr_vec;
  logic [ID_W-1:0]     int_id;
  logic                sint;

  // ---------------------------------------------------------------------------
  // Request and priority encode (lowest index wins, timer last)
  // ---------------------------------------------------------------------------
  assign active = pend & ~MASK;
  assign sint   = |active;

  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    int_id = '0;
    // Scan downward so the last hit written is the lowest active index.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) int_id = ID_W'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Pending set/clear. Set is OR-ed after clear so a simultaneous new edge
  // and acknowledge of the same bit leaves it pending.
  // ---------------------------------------------------------------------------
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_vec[i] = ACK && sint && (int_id == ID_W'(i));
    end
  end

  assign set_vec = {expire, (SAMP ? (INTR & ~prev) : '0)};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, matching the hardware.
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      prev <= '0;
      pend <= '0;
    end else begin
      if (SAMP) prev <= INTR;
      pend <= (pend & ~clr_vec) | set_vec;
    end
  end

  // ---------------------------------------------------------------------------
  // Countdown timer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state   <= IDLE;
      cnt     <= '0;
      tc_done <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      tc_done <= expire;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    expire     = 1'b0;
    if (CNT_LOAD) begin
      // Load has priority over a step in the same cycle; zero parks the
      // timer without raising an interrupt.
      cnt_next   = CNT_VAL;
      state_next = (CNT_VAL != '0) ? RUN : IDLE;
    end else if (state == RUN && CNT_STEP) begin
      cnt_next = cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        state_next = IDLE;
        expire     = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign SINT     = sint;
  assign INT_ID   = int_id;
  assign INT_PEND = pend;
  assign CNT      = cnt;
  assign TC_DONE  = tc_done;

endmodule

// File: tb/tb_lvda_int_countdn_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lvda_int_countdn_ctrl
//
// Self-checking bench for lvda_int_countdn_ctrl. Directed scenarios cover
// priority, edge detection, masking, the timer, collisions and asynchronous
// reset; a randomized phase compares against a behavioural model.
// -----------------------------------------------------------------------------
module tb_lvda_int_countdn_ctrl;

  localparam int N  = 7;
  localparam int CW = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          samp;
  logic [N-1:0]  intr;
  logic [N:0]    mask;
  logic          ack;
  logic          cnt_load;
  logic [CW-1:0] cnt_val;
  logic          cnt_step;
  logic          sint;
  logic [IW-1:0] int_id;
  logic [N:0]    int_pend;
  logic [CW-1:0] cnt;
  logic          tc_done;

  lvda_int_countdn_ctrl #(.NUM_INTR(N), .CNT_W(CW), .ID_W(IW)) dut (
    .SIM_CLK  (clk),
    .SIM_RST  (rst),
    .SAMP     (samp),
    .INTR     (intr),
    .MASK     (mask),
    .ACK      (ack),
    .CNT_LOAD (cnt_load),
    .CNT_VAL  (cnt_val),
    .CNT_STEP (cnt_step),
    .SINT     (sint),
    .INT_ID   (int_id),
    .INT_PEND (int_pend),
    .CNT      (cnt),
    .TC_DONE  (tc_done)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // ---------------------------------------------------------------------------
  // Behavioural model: pending set as a bit list, counter as a plain integer.
  // ---------------------------------------------------------------------------
  logic [N:0]   m_pend;
  logic [N-1:0] m_prev;
  int           m_cnt;
  bit           m_run;
  bit           m_tc;

  function automatic int m_id();
    for (int i = 0; i <= N; i++) if (m_pend[i] && !mask[i]) return i;
    return 0;
  endfunction

  function automatic bit m_sint();
    for (int i = 0; i <= N; i++) if (m_pend[i] && !mask[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_prev = '0;
    m_cnt  = 0;
    m_run  = 1'b0;
    m_tc   = 1'b0;
  endtask

  // Advance the model by one clock with the current inputs, then clock the
  // DUT and return #1 after the edge with pulse inputs cleared.
  task automatic tick();
    logic [N:0] nxt;
    bit fire;
    nxt  = m_pend;
    fire = 1'b0;
    if (ack && m_sint()) nxt[m_id()] = 1'b0;
    if (samp) begin
      for (int i = 0; i < N; i++) if (intr[i] && !m_prev[i]) nxt[i] = 1'b1;
      m_prev = intr;
    end
    if (cnt_load) begin
      m_cnt = int'(cnt_val);
      m_run = (cnt_val != 0);
    end else if (m_run && cnt_step) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_run = 1'b0;
        fire  = 1'b1;
      end
    end
    if (fire) nxt[N] = 1'b1;
    m_tc   = fire;
    m_pend = nxt;
    @(posedge clk);
    #1;
    samp     = 1'b0;
    ack      = 1'b0;
    cnt_load = 1'b0;
    cnt_step = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; samp = 0; intr = '0; mask = '0; ack = 0;
    cnt_load = 0; cnt_val = '0; cnt_step = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if ({sint, int_id, int_pend, cnt, tc_done} !== '0)
      $display("FAIL reset_outputs: got sint=%b id=%0d pend=%h cnt=%0d tc=%b want all 0", sint, int_id, int_pend, cnt, tc_done);
    else n_pass++;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_priority();
    intr = 7'b0100100; samp = 1; tick();
    n_total++; if (int_pend !== 8'h24) $display("FAIL prio_pend: got %h want 24", int_pend); else n_pass++;
    n_total++; if (sint !== 1'b1 || int_id !== 3'd2) $display("FAIL prio_first: got sint=%b id=%0d want 1/2", sint, int_id); else n_pass++;
    ack = 1; tick();
    n_total++; if (sint !== 1'b1 || int_id !== 3'd5) $display("FAIL prio_second: got sint=%b id=%0d want 1/5", sint, int_id); else n_pass++;
    ack = 1; tick();
    n_total++; if (sint !== 1'b0 || int_id !== 3'd0 || int_pend !== 8'h00)
      $display("FAIL prio_drained: got sint=%b id=%0d pend=%h want 0/0/00", sint, int_id, int_pend);
    else n_pass++;
    intr = '0; samp = 1; tick();
  endtask

  task automatic test_edge_only();
    intr = 7'h01; samp = 1; tick();
    n_total++; if (int_pend[0] !== 1'b1) $display("FAIL edge_first: got %b want 1", int_pend[0]); else n_pass++;
    samp = 1; ack = 1; tick();
    for (int k = 0; k < 2; k++) begin
      n_total++; if (int_pend[0] !== 1'b0) $display("FAIL edge_held%0d: got %b want 0", k, int_pend[0]); else n_pass++;
      samp = 1; tick();
    end
    n_total++; if (int_pend[0] !== 1'b0) $display("FAIL edge_held_last: got %b want 0", int_pend[0]); else n_pass++;
    intr = '0; samp = 1; tick();
    intr = 7'h01; samp = 1; tick();
    n_total++; if (int_pend[0] !== 1'b1) $display("FAIL edge_repend: got %b want 1", int_pend[0]); else n_pass++;
    ack = 1; tick();
    intr = '0; samp = 1; tick();
  endtask

  task automatic test_mask();
    mask = 8'h01; intr = 7'h01; samp = 1; tick();
    n_total++; if (int_pend[0] !== 1'b1 || sint !== 1'b0 || int_id !== 3'd0)
      $display("FAIL mask_blocked: got pend0=%b sint=%b id=%0d want 1/0/0", int_pend[0], sint, int_id);
    else n_pass++;
    mask = 8'h00;
    #1;
    n_total++; if (sint !== 1'b1 || int_id !== 3'd0) $display("FAIL mask_unmask_comb: got sint=%b id=%0d want 1/0", sint, int_id); else n_pass++;
    ack = 1; tick();
    intr = '0; samp = 1; tick();
  endtask

  task automatic test_timer();
    cnt_load = 1; cnt_val = 8'd3; tick();
    n_total++; if (cnt !== 8'd3 || tc_done !== 1'b0) $display("FAIL timer_load: got cnt=%0d tc=%b want 3/0", cnt, tc_done); else n_pass++;
    for (int k = 2; k >= 0; k--) begin
      cnt_step = 1; tick();
      n_total++; if (cnt !== CW'(k) || tc_done !== (k == 0))
        $display("FAIL timer_step%0d: got cnt=%0d tc=%b want %0d/%0b", k, cnt, tc_done, k, (k == 0));
      else n_pass++;
    end
    n_total++; if (sint !== 1'b1 || int_id !== 3'd7) $display("FAIL timer_irq: got sint=%b id=%0d want 1/7", sint, int_id); else n_pass++;
    cnt_step = 1; tick();
    n_total++; if (cnt !== 8'd0 || tc_done !== 1'b0) $display("FAIL timer_after: got cnt=%0d tc=%b want 0/0", cnt, tc_done); else n_pass++;
    ack = 1; tick();
    cnt_load = 1; cnt_val = 8'd0; tick();
    cnt_step = 1; tick();
    n_total++; if (tc_done !== 1'b0 || int_pend !== 8'h00 || cnt !== 8'd0)
      $display("FAIL timer_load0: got tc=%b pend=%h cnt=%0d want 0/00/0", tc_done, int_pend, cnt);
    else n_pass++;
  endtask

  task automatic test_collisions();
    cnt_load = 1; cnt_val = 8'd5; cnt_step = 1; tick();
    n_total++; if (cnt !== 8'd5) $display("FAIL coll_load_step: got %0d want 5", cnt); else n_pass++;
    intr = 7'h08; samp = 1; tick();
    n_total++; if (int_id !== 3'd3 || sint !== 1'b1) $display("FAIL coll_id3: got sint=%b id=%0d want 1/3", sint, int_id); else n_pass++;
    intr = '0; samp = 1; tick();
    intr = 7'h08; samp = 1; ack = 1; tick();
    n_total++; if (int_pend[3] !== 1'b1) $display("FAIL coll_set_wins: got %b want 1", int_pend[3]); else n_pass++;
    ack = 1; tick();
    intr = '0; samp = 1; tick();
  endtask

  task automatic test_async_reset();
    cnt_load = 1; cnt_val = 8'd1; tick();
    cnt_step = 1; tick();
    intr = '0; samp = 1; tick();
    intr = 7'h7F; samp = 1; cnt_load = 1; cnt_val = 8'd200; tick();
    n_total++; if (int_pend !== 8'hFF || cnt !== 8'd200) $display("FAIL areset_pre: got pend=%h cnt=%0d want FF/200", int_pend, cnt); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_total++; if ({sint, int_id, int_pend, cnt, tc_done} !== '0)
      $display("FAIL areset_immediate: got sint=%b id=%0d pend=%h cnt=%0d tc=%b want all 0", sint, int_id, int_pend, cnt, tc_done);
    else n_pass++;
    model_reset();
    #1 rst = 1'b0;
    samp = 1; tick();
    n_total++; if (int_pend !== 8'h7F) $display("FAIL areset_resample: got %h want 7F", int_pend); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      samp     = ($urandom_range(0, 1) == 1);
      intr     = N'($urandom);
      if ($urandom_range(0, 7) == 0) mask = (N + 1)'($urandom);
      ack      = ($urandom_range(0, 2) == 0);
      cnt_load = ($urandom_range(0, 9) == 0);
      cnt_val  = CW'($urandom_range(0, 6));
      cnt_step = ($urandom_range(0, 1) == 1);
      #1;
      n_total++; if (sint !== m_sint() || int_id !== IW'(m_id()))
        $display("FAIL rand_req%0d: got sint=%b id=%0d want %b/%0d", it, sint, int_id, m_sint(), m_id());
      else n_pass++;
      tick();
      n_total++; if (int_pend !== m_pend || cnt !== CW'(m_cnt) || tc_done !== m_tc)
        $display("FAIL rand_state%0d: got pend=%h cnt=%0d tc=%b want %h/%0d/%b", it, int_pend, cnt, tc_done, m_pend, m_cnt, m_tc);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_edge_only();
    test_mask();
    test_timer();
    test_collisions();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
